// File: rtl/sum_stationary_drain.sv
// -----------------------------------------------------------------------------
// sum_stationary_drain
//
// Downstream consumer of an NxN sum-stationary matrix-multiply array. When the
// array reports valid results, all N*N accumulated sums are captured into a
// local buffer in a single cycle. A one-cycle clear pulse is then returned to
// the array so it can start its next multiplication. Meanwhile, the buffered
// results stream out one matrix row per beat on a valid/ready interface.
//
// Ports:
//   clk_i        : clock, rising edge
//   reset_i      : asynchronous, active-high reset
//   mm_valid_i   : array results valid (held by the array until cleared)
//   mm_c_i       : N*N results, row-major, element i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
//   mm_clear_o   : one-cycle pulse asking the array to reset and restart
//   row_valid_o  : output row valid
//   row_ready_i  : consumer accepts the current row
//   row_data_o   : current row, element k at [k*C_DATA_WIDTH +: C_DATA_WIDTH]
//   row_idx_o    : index of the current row
//   row_last_o   : current row is the final row of the matrix
//   busy_o       : buffer holds undrained results
// -----------------------------------------------------------------------------
module sum_stationary_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int N            = 4,
   parameter int C_DATA_WIDTH = (2*DATA_WIDTH)+$clog2(N)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           mm_valid_i,
   input  logic [N*N*C_DATA_WIDTH-1:0]    mm_c_i,
   output logic                           mm_clear_o,
   output logic                           row_valid_o,
   input  logic                           row_ready_i,
   output logic [N*C_DATA_WIDTH-1:0]      row_data_o,
   output logic [$clog2(N)-1:0]           row_idx_o,
   output logic                           row_last_o,
   output logic                           busy_o
);

   localparam int              W        = C_DATA_WIDTH;
   localparam int              RW       = $clog2(N);
   localparam logic [RW-1:0]   LAST_ROW = RW'(N-1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     r_q, r_d;
   logic              clear_q, clear_d;
   logic [W-1:0]      buf_q [N*N];

   logic              capture;
   int unsigned       row_base;

   // Capture is only possible in IDLE, so data presented during SEND is ignored
   // and the array simply holds it until the drain completes.
   assign capture  = (state_q == IDLE) && mm_valid_i;
   assign row_base = 32'(r_q) * 32'(N);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         r_q     <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         clear_q <= clear_d;
      end
   end

   // --------------------------------------------------------------------------
   // Result buffer: whole matrix loaded in one cycle on capture
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < N*N; i++) begin
            buf_q[i] <= '0;
         end
      end else if (capture) begin
         for (int unsigned i = 0; i < N*N; i++) begin
            buf_q[i] <= mm_c_i[i*W +: W];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      clear_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mm_valid_i) begin
               state_d = SEND;
               r_d     = '0;
               clear_d = 1'b1;
            end
         end
         SEND: begin
            // row_valid_o is high throughout SEND, so ready alone completes a beat
            if (row_ready_i) begin
               if (r_q == LAST_ROW) begin
                  r_d     = '0;
                  state_d = IDLE;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            r_d     = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output logic: decoded from registered state only
   // --------------------------------------------------------------------------
   always_comb begin
      row_valid_o = (state_q == SEND);
      busy_o      = (state_q == SEND);
      row_last_o  = (state_q == SEND) && (r_q == LAST_ROW);
      row_idx_o   = r_q;
      mm_clear_o  = clear_q;
   end

   always_comb begin
      row_data_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         row_data_o[k*W +: W] = buf_q[row_base + k];
      end
   end

endmodule

// File: tb/tb_sum_stationary_drain.sv
module tb_sum_stationary_drain;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int CW = (2*DW)+$clog2(N);
   localparam int IW = $clog2(N);

   logic                  clk = 1'b0;
   logic                  reset_i;
   logic                  mm_valid_i;
   logic [N*N*CW-1:0]     mm_c_i;
   logic                  mm_clear_o;
   logic                  row_valid_o;
   logic                  row_ready_i;
   logic [N*CW-1:0]       row_data_o;
   logic [IW-1:0]         row_idx_o;
   logic                  row_last_o;
   logic                  busy_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sum_stationary_drain #(
      .DATA_WIDTH(DW),
      .N(N)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .mm_valid_i(mm_valid_i),
      .mm_c_i(mm_c_i),
      .mm_clear_o(mm_clear_o),
      .row_valid_o(row_valid_o),
      .row_ready_i(row_ready_i),
      .row_data_o(row_data_o),
      .row_idx_o(row_idx_o),
      .row_last_o(row_last_o),
      .busy_o(busy_o)
   );

   // Scoreboard of expected rows, in emission order
   logic [N*CW-1:0] q_data[$];
   int              q_idx[$];
   int              captures = 0;
   int              clears   = 0;

   int ready_mode = 0;
   int stall_cnt  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Consumer ready generation
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: row_ready_i = 1'b1;
         1: row_ready_i = ($urandom_range(0, 3) != 0);
         default: begin
            if (row_valid_o && row_idx_o == 1 && stall_cnt < 3) begin
               row_ready_i = 1'b0;
               stall_cnt++;
            end else begin
               row_ready_i = 1'b1;
            end
         end
      endcase
   end

   // Monitor: protocol model plus scoreboard comparison
   logic prev_ok   = 1'b0;
   logic prev_rv   = 1'b0;
   logic prev_mmv  = 1'b0;
   logic prev_rdy  = 1'b0;
   logic prev_last = 1'b0;
   logic exp_start, exp_rv, front_last;

   always @(negedge clk) begin
      if (reset_i) begin
         prev_ok = 1'b0;
      end else begin
         if (prev_ok) begin
            exp_start = !prev_rv && prev_mmv;
            exp_rv    = exp_start || (prev_rv && !(prev_rdy && prev_last));
            check("clear_pulse", mm_clear_o, exp_start);
            check("row_valid", row_valid_o, exp_rv);
         end
         check("busy", busy_o, row_valid_o);
         if (mm_clear_o) clears++;
         front_last = 1'b0;
         if (row_valid_o) begin
            if (q_data.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_row actual=idx%0d required=no_row", row_idx_o);
            end else begin
               for (int k = 0; k < N; k++) begin
                  check("row_data", row_data_o[k*CW +: CW], q_data[0][k*CW +: CW]);
               end
               check("row_idx", row_idx_o, q_idx[0]);
               front_last = (q_idx[0] == N-1);
               check("row_last", row_last_o, front_last);
               if (row_ready_i) begin
                  void'(q_data.pop_front());
                  void'(q_idx.pop_front());
               end
            end
         end else begin
            check("row_last_idle", row_last_o, 1'b0);
         end
         prev_rv   = row_valid_o;
         prev_mmv  = mm_valid_i;
         prev_rdy  = row_ready_i;
         prev_last = front_last;
         prev_ok   = 1'b1;
      end
   end

   // Array model: present a matrix with valid and expect its rows
   task automatic present(input logic [N*N*CW-1:0] m);
      mm_c_i     = m;
      mm_valid_i = 1'b1;
      for (int r = 0; r < N; r++) begin
         q_data.push_back(m[r*N*CW +: N*CW]);
         q_idx.push_back(r);
      end
      captures++;
   endtask

   task automatic await_clear();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mm_clear_o && n < 200);
      total++;
      if (!mm_clear_o) begin
         bad++;
         $display("FAIL clear_timeout actual=no_clear required=clear");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q_data.size() != 0 || row_valid_o) && n < 500);
      total++;
      if (q_data.size() != 0 || row_valid_o) begin
         bad++;
         $display("FAIL drain_timeout actual=%0d_rows_left required=0", q_data.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs();
      check("rst_clear", mm_clear_o, 1'b0);
      check("rst_valid", row_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_last", row_last_o, 1'b0);
      check("rst_idx", row_idx_o, '0);
      for (int k = 0; k < N; k++) begin
         check("rst_data", row_data_o[k*CW +: CW], '0);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_valid", row_valid_o, 1'b0);
         check("idle_clear", mm_clear_o, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
   endtask

   logic [N*N*CW-1:0] m;

   initial begin
      reset_i     = 1'b0;
      mm_valid_i  = 1'b0;
      mm_c_i      = '0;
      row_ready_i = 1'b1;

      // Asynchronous reset mid-cycle, outputs must clear before any edge
      @(posedge clk);
      #3;
      reset_i = 1'b1;
      #1;
      check_zero_outputs();
      release_reset();
      idle_cycles(20);

      // Basic drain: element i = i
      ready_mode = 0;
      for (int i = 0; i < N*N; i++) m[i*CW +: CW] = CW'(i);
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      wait_drain();

      // Back-pressure on row 1 while the array input changes
      ready_mode = 2;
      stall_cnt  = 0;
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      for (int i = 0; i < N*N; i++) mm_c_i[i*CW +: CW] = CW'(7);
      wait_drain();
      check("stall_cycles", stall_cnt, 3);

      // Back-to-back: next matrix valid throughout the drain
      ready_mode = 0;
      present(m);
      await_clear();
      for (int i = 0; i < N*N; i++) m[i*CW +: CW] = CW'(100 + i);
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      wait_drain();

      // Reset mid-operation at row 2
      for (int i = 0; i < N*N; i++) m[i*CW +: CW] = CW'($urandom);
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(row_valid_o && row_idx_o == 2) && n < 100);
         check("reach_row2", row_idx_o, 2);
      end
      #1;
      reset_i = 1'b1;
      q_data.delete();
      q_idx.delete();
      #1;
      check_zero_outputs();
      release_reset();
      idle_cycles(20);
      for (int i = 0; i < N*N; i++) m[i*CW +: CW] = CW'($urandom);
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      wait_drain();

      // Width extreme: all ones
      for (int i = 0; i < N*N; i++) m[i*CW +: CW] = '1;
      present(m);
      await_clear();
      mm_valid_i = 1'b0;
      wait_drain();

      // Random matrices, random ready, mixed gaps and back-to-back
      ready_mode = 1;
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < N*N; i++) m[i*CW +: CW] = CW'($urandom);
         present(m);
         await_clear();
         if ($urandom_range(0, 1) == 0) begin
            mm_valid_i = 1'b0;
            for (int g = $urandom_range(0, 6); g > 0; g--) @(posedge clk);
            #1;
         end
      end
      mm_valid_i = 1'b0;
      ready_mode = 0;
      wait_drain();

      check("clear_count", clears, captures);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
